// File: rtl/ahb_slave_port.sv
// AHB-Lite slave port bridging AHB transfers onto a simple backend strobe
// interface, with burst tracking, protocol checking and a backend wait timeout.
//
// Ports:
//   ahb_clk_in / ahb_rstn_in      clock, asynchronous active-low reset
//   ahb_sel_in .. ahb_ready_in    AHB address/data phase inputs (HSEL..HREADY)
//   ahb_rdata_out/ready/resp_out  AHB response (HRDATA, HREADYOUT, HRESP)
//   other_*_out                   backend access strobe, address, control, write data
//   other_rdata/ready/error_in    backend read data, completion, error
module ahb_slave_port #(
  parameter int unsigned AHB_DATA_WIDTH   = 32,
  parameter int unsigned AHB_ADDR_WIDTH   = 32,
  parameter int unsigned AHB_WAIT_TIMEOUT = 6
) (
  input  logic                      ahb_clk_in,
  input  logic                      ahb_rstn_in,
  input  logic                      ahb_sel_in,
  input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
  input  logic [1:0]                ahb_trans_in,
  input  logic                      ahb_write_in,
  input  logic [2:0]                ahb_size_in,
  input  logic [2:0]                ahb_burst_in,
  input  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in,
  input  logic                      ahb_ready_in,
  output logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out,
  output logic                      ahb_ready_out,
  output logic                      ahb_resp_out,
  output logic                      other_sel_out,
  output logic [AHB_ADDR_WIDTH-1:0] other_addr_out,
  output logic                      other_write_out,
  output logic [2:0]                other_size_out,
  output logic [AHB_DATA_WIDTH-1:0] other_wdata_out,
  input  logic [AHB_DATA_WIDTH-1:0] other_rdata_in,
  input  logic                      other_ready_in,
  input  logic                      other_error_in
);

  localparam int unsigned DW  = AHB_DATA_WIDTH;
  localparam int unsigned AW  = AHB_ADDR_WIDTH;
  localparam int unsigned WCW = $clog2(AHB_WAIT_TIMEOUT + 1);
  localparam int unsigned BCW = 5;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [2:0] BU_SINGLE = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR1   = 2'd2,
    ST_ERR2   = 2'd3
  } state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [2:0]    size;
    logic [2:0]    burst;
  } xfer_t;

  // Beats in a fixed-length burst; 0 means unbounded (SINGLE/INCR).
  function automatic logic [BCW-1:0] burst_len(input logic [2:0] burst);
    case (burst)
      3'd2, 3'd3: burst_len = BCW'(4);
      3'd4, 3'd5: burst_len = BCW'(8);
      3'd6, 3'd7: burst_len = BCW'(16);
      default:    burst_len = '0;
    endcase
  endfunction

  // Address the next SEQ beat must carry; wrapping bursts stay in their window.
  function automatic logic [AW-1:0] calc_next(input logic [AW-1:0] addr,
                                              input logic [2:0]    size,
                                              input logic [2:0]    burst);
    logic [AW-1:0] incr;
    logic [AW-1:0] mask;
    incr = AW'(1) << size;
    mask = '0;
    case (burst)
      3'd2:    mask = (incr << 2) - AW'(1);
      3'd4:    mask = (incr << 3) - AW'(1);
      3'd6:    mask = (incr << 4) - AW'(1);
      default: mask = '0;
    endcase
    if (mask != '0) calc_next = (addr & ~mask) | ((addr + incr) & mask);
    else            calc_next = addr + incr;
  endfunction

  state_e         state_q, state_d;
  xfer_t          xfer_q, xfer_d;
  logic           burst_act_q, burst_act_d;
  logic [BCW-1:0] beat_q, beat_d;
  logic [AW-1:0]  next_addr_q, next_addr_d;
  logic [WCW-1:0] wait_q, wait_d;

  logic           take;
  logic           perr;
  logic [10:0]    size_bits;
  logic           size_bad;
  logic           seq_over;
  logic [BCW-1:0] cur_len;
  logic [WCW-1:0] wait_inc;

  assign size_bits = 11'(8) << ahb_size_in;
  assign size_bad  = size_bits > 11'(DW);
  assign cur_len   = burst_len(xfer_q.burst);
  assign seq_over  = (cur_len != '0) && (beat_q >= cur_len);
  assign wait_inc  = wait_q + WCW'(1);

  // State and transfer registers.
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      state_q     <= ST_IDLE;
      xfer_q      <= '0;
      burst_act_q <= 1'b0;
      beat_q      <= '0;
      next_addr_q <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      xfer_q      <= xfer_d;
      burst_act_q <= burst_act_d;
      beat_q      <= beat_d;
      next_addr_q <= next_addr_d;
      wait_q      <= wait_d;
    end
  end

  // Next state, address-phase sampling and response outputs.
  always_comb begin
    state_d         = state_q;
    xfer_d          = xfer_q;
    burst_act_d     = burst_act_q;
    beat_d          = beat_q;
    next_addr_d     = next_addr_q;
    wait_d          = wait_q;
    take            = 1'b0;
    perr            = 1'b0;
    other_sel_out   = 1'b0;
    ahb_ready_out   = 1'b1;
    ahb_resp_out    = 1'b0;
    ahb_rdata_out   = '0;

    case (state_q)
      ST_IDLE: take = 1'b1;
      ST_ACCESS: begin
        other_sel_out = 1'b1;
        ahb_ready_out = other_ready_in & ~other_error_in;
        if (!xfer_q.write) ahb_rdata_out = other_rdata_in;
        if (other_ready_in) begin
          if (other_error_in) state_d = ST_ERR1;
          else                take    = 1'b1;
        end else if (wait_inc == WCW'(AHB_WAIT_TIMEOUT)) begin
          state_d = ST_ERR1;
        end else begin
          wait_d = wait_inc;
        end
      end
      ST_ERR1: begin
        ahb_ready_out = 1'b0;
        ahb_resp_out  = 1'b1;
        state_d       = ST_ERR2;
      end
      ST_ERR2: begin
        ahb_resp_out = 1'b1;
        take         = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Address phase is only accepted when the previous data phase ends OKAY/ERR2.
    if (take) begin
      state_d = ST_IDLE;
      if (ahb_sel_in && ahb_ready_in) begin
        case (ahb_trans_in)
          TR_IDLE:   burst_act_d = 1'b0;
          TR_BUSY:   perr = ~burst_act_q;
          TR_NONSEQ: perr = size_bad;
          default:   perr = size_bad | ~burst_act_q | (ahb_addr_in != next_addr_q) |
                            (ahb_burst_in != xfer_q.burst) | seq_over;
        endcase
        if (perr) begin
          state_d = ST_ERR1;
        end else if (ahb_trans_in[1]) begin
          state_d      = ST_ACCESS;
          xfer_d.addr  = ahb_addr_in;
          xfer_d.write = ahb_write_in;
          xfer_d.size  = ahb_size_in;
          xfer_d.burst = ahb_burst_in;
          wait_d       = '0;
          next_addr_d  = calc_next(ahb_addr_in, ahb_size_in, ahb_burst_in);
          if (ahb_trans_in == TR_NONSEQ) begin
            beat_d      = BCW'(1);
            burst_act_d = (ahb_burst_in != BU_SINGLE);
          end else if (beat_q != '1) begin
            beat_d = beat_q + BCW'(1);
          end
        end
      end
    end

    // Any error response cancels the burst in progress.
    if (state_d == ST_ERR1) burst_act_d = 1'b0;
  end

  assign other_addr_out  = xfer_q.addr;
  assign other_write_out = xfer_q.write;
  assign other_size_out  = xfer_q.size;
  assign other_wdata_out = ahb_wdata_in;

endmodule

// File: tb/tb_ahb_slave_port.sv
// Directed bench for ahb_slave_port: a transaction-level model expands each
// address phase into the per-cycle response it must produce, and every cycle
// the DUT outputs are compared against that expansion.
module tb_ahb_slave_port;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 6;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic          clk;
  logic          rstn;
  logic          sel;
  logic [AW-1:0] addr;
  logic [1:0]    trans;
  logic          write;
  logic [2:0]    size;
  logic [2:0]    burst;
  logic [DW-1:0] wdata;
  logic          hready;
  logic [DW-1:0] rdata_out;
  logic          ready_out;
  logic          resp_out;
  logic          osel;
  logic [AW-1:0] oaddr;
  logic          owrite;
  logic [2:0]    osize;
  logic [DW-1:0] owdata;
  logic [DW-1:0] ordata;
  logic          ordy;
  logic          oerr;

  assign hready = ready_out;

  ahb_slave_port #(
    .AHB_DATA_WIDTH  (DW),
    .AHB_ADDR_WIDTH  (AW),
    .AHB_WAIT_TIMEOUT(TO)
  ) dut (
    .ahb_clk_in     (clk),
    .ahb_rstn_in    (rstn),
    .ahb_sel_in     (sel),
    .ahb_addr_in    (addr),
    .ahb_trans_in   (trans),
    .ahb_write_in   (write),
    .ahb_size_in    (size),
    .ahb_burst_in   (burst),
    .ahb_wdata_in   (wdata),
    .ahb_ready_in   (hready),
    .ahb_rdata_out  (rdata_out),
    .ahb_ready_out  (ready_out),
    .ahb_resp_out   (resp_out),
    .other_sel_out  (osel),
    .other_addr_out (oaddr),
    .other_write_out(owrite),
    .other_size_out (osize),
    .other_wdata_out(owdata),
    .other_rdata_in (ordata),
    .other_ready_in (ordy),
    .other_error_in (oerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    bit          berr;
  } xfer_t;

  // One data-phase cycle: what to drive on the backend and what must come out.
  typedef struct {
    bit          ordy;
    bit          oerr;
    logic [31:0] ordata;
    logic [31:0] wdata;
    bit          e_ready;
    bit          e_resp;
    bit          e_sel;
    logic [31:0] e_addr;
    bit          e_write;
    logic [2:0]  e_size;
    logic [31:0] e_rdata;
  } cyc_t;

  xfer_t       xq[$];
  cyc_t        dq[$];
  bit          m_on;
  logic [2:0]  m_burst;
  logic [31:0] m_next;
  int          m_beats;
  int          checks;
  int          failures;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic xfer_t mk(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                               input logic [2:0] sz, input logic [2:0] bu, input logic [31:0] wd,
                               input logic [31:0] rd, input int w, input bit be);
    xfer_t t;
    t.trans = tr; t.addr = a; t.write = wr; t.size = sz; t.burst = bu;
    t.wdata = wd; t.rdata = rd; t.waits = w; t.berr = be;
    return t;
  endfunction

  function automatic int model_len(input logic [2:0] bu);
    case (bu)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 0;
    endcase
  endfunction

  // Next beat address from plain arithmetic: wrap within an aligned window of beats*incr bytes.
  function automatic logic [31:0] model_next(input logic [31:0] a, input logic [2:0] sz,
                                             input logic [2:0] bu);
    logic [31:0] incr;
    logic [31:0] span;
    logic [31:0] base;
    incr = 32'(1) << sz;
    if (bu == 3'd0 || bu[0]) return a + incr;
    span = 32'(model_len(bu)) * incr;
    base = (a / span) * span;
    return base + ((a - base + incr) % span);
  endfunction

  function automatic cyc_t idle_cyc();
    cyc_t c;
    c.ordy = 1'b1; c.oerr = 1'b0; c.ordata = JUNK; c.wdata = 32'h0;
    c.e_ready = 1'b1; c.e_resp = 1'b0; c.e_sel = 1'b0;
    c.e_addr = 32'h0; c.e_write = 1'b0; c.e_size = 3'd0; c.e_rdata = 32'h0;
    return c;
  endfunction

  function automatic cyc_t acc_cyc(input xfer_t t, input bit rdy, input bit err);
    cyc_t c;
    c.ordy = rdy; c.oerr = err; c.ordata = t.rdata; c.wdata = t.wdata;
    c.e_ready = rdy && !err; c.e_resp = 1'b0; c.e_sel = 1'b1;
    c.e_addr = t.addr; c.e_write = t.write; c.e_size = t.size;
    c.e_rdata = t.write ? 32'h0 : t.rdata;
    return c;
  endfunction

  task automatic push_err();
    cyc_t c;
    c = idle_cyc();
    c.oerr = 1'b1; c.e_ready = 1'b0; c.e_resp = 1'b1;
    dq.push_back(c);
    c.e_ready = 1'b1;
    dq.push_back(c);
    m_on = 1'b0;
  endtask

  // Expand one accepted address phase into its expected data-phase cycles.
  task automatic model_accept(input xfer_t t);
    bit perr;
    bit size_bad;
    int nw;
    perr = 1'b0;
    size_bad = (32'(8) << t.size) > 32'(DW);
    case (t.trans)
      2'd0: m_on = 1'b0;
      2'd1: perr = !m_on;
      2'd2: perr = size_bad;
      default: perr = size_bad || !m_on || (t.addr != m_next) || (t.burst != m_burst) ||
                      (model_len(m_burst) != 0 && m_beats >= model_len(m_burst));
    endcase
    if (perr) begin
      push_err();
      return;
    end
    if (t.trans < 2'd2) begin
      dq.push_back(idle_cyc());
      return;
    end
    if (t.trans == 2'd2) begin
      m_on = (t.burst != 3'd0);
      m_burst = t.burst;
      m_beats = 1;
    end else begin
      m_beats++;
    end
    m_next = model_next(t.addr, t.size, t.burst);
    nw = (t.waits < int'(TO)) ? t.waits : int'(TO);
    for (int i = 0; i < nw; i++) dq.push_back(acc_cyc(t, 1'b0, 1'b0));
    if (t.waits >= int'(TO)) begin
      push_err();
    end else begin
      dq.push_back(acc_cyc(t, 1'b1, t.berr));
      if (t.berr) push_err();
    end
  endtask

  task automatic compare(input cyc_t c);
    chk("hready", 64'(ready_out), 64'(c.e_ready));
    chk("hresp", 64'(resp_out), 64'(c.e_resp));
    chk("bsel", 64'(osel), 64'(c.e_sel));
    chk("hrdata", 64'(rdata_out), 64'(c.e_rdata));
    if (c.e_sel) begin
      chk("baddr", 64'(oaddr), 64'(c.e_addr));
      chk("bwrite", 64'(owrite), 64'(c.e_write));
      chk("bsize", 64'(osize), 64'(c.e_size));
      chk("bwdata", 64'(owdata), 64'(c.wdata));
    end
  endtask

  // One clock: data phase from the model queue, next address phase when ready is expected.
  task automatic cycle();
    cyc_t  cur;
    xfer_t nx;
    bit    have_addr;
    if (dq.size() > 0) cur = dq.pop_front();
    else               cur = idle_cyc();
    have_addr = cur.e_ready && (xq.size() > 0);
    if (have_addr) begin
      nx = xq.pop_front();
      sel = 1'b1; trans = nx.trans; addr = nx.addr; write = nx.write;
      size = nx.size; burst = nx.burst;
    end else begin
      sel = 1'b0; trans = 2'd0; addr = 32'h0; write = 1'b0; size = 3'd0; burst = 3'd0;
    end
    ordy = cur.ordy; oerr = cur.oerr; ordata = cur.ordata; wdata = cur.wdata;
    @(negedge clk);
    compare(cur);
    if (have_addr) model_accept(nx);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((xq.size() > 0 || dq.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (xq.size() > 0 || dq.size() > 0) begin
      failures++;
      $display("FAIL run_budget: %0d items left after %0d cycles", xq.size() + dq.size(), n);
      xq.delete();
      dq.delete();
    end
    cycle();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bsel"}, 64'(osel), 64'(0));
    chk({tag, "_baddr"}, 64'(oaddr), 64'(0));
    chk({tag, "_bwrite"}, 64'(owrite), 64'(0));
    chk({tag, "_bsize"}, 64'(osize), 64'(0));
    chk({tag, "_hready"}, 64'(ready_out), 64'(1));
    chk({tag, "_hresp"}, 64'(resp_out), 64'(0));
    chk({tag, "_hrdata"}, 64'(rdata_out), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    m_on = 1'b0; m_burst = 3'd0; m_next = 32'h0; m_beats = 0;
    rstn = 1'b0; sel = 1'b0; addr = 32'h0; trans = 2'd0; write = 1'b0;
    size = 3'd0; burst = 3'd0; wdata = 32'h0; ordata = JUNK; ordy = 1'b1; oerr = 1'b0;

    // Hand-computed pins on the address model.
    chk("pin_wrap4_38", 64'(model_next(32'h38, 3'd2, 3'd2)), 64'h3C);
    chk("pin_wrap4_3c", 64'(model_next(32'h3C, 3'd2, 3'd2)), 64'h30);
    chk("pin_wrap4_30", 64'(model_next(32'h30, 3'd2, 3'd2)), 64'h34);
    chk("pin_incr4_34", 64'(model_next(32'h34, 3'd2, 3'd3)), 64'h38);
    chk("pin_wrap8_7c", 64'(model_next(32'h7C, 3'd2, 3'd4)), 64'h60);

    #22;
    chk_reset_outputs("por");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single write, zero wait.
    xq.push_back(mk(2'd2, 32'h100, 1'b1, 3'd2, 3'd0, 32'hA5A5_0001, JUNK, 0, 1'b0));
    run(20);

    // WRAP4 read through the wrap, then a bad SEQ address at beat 2.
    xq.push_back(mk(2'd2, 32'h38, 1'b0, 3'd2, 3'd2, 32'h0, 32'h1111_0038, 0, 1'b0));
    xq.push_back(mk(2'd3, 32'h3C, 1'b0, 3'd2, 3'd2, 32'h0, 32'h1111_003C, 0, 1'b0));
    xq.push_back(mk(2'd3, 32'h30, 1'b0, 3'd2, 3'd2, 32'h0, 32'h1111_0030, 1, 1'b0));
    xq.push_back(mk(2'd3, 32'h34, 1'b0, 3'd2, 3'd2, 32'h0, 32'h1111_0034, 0, 1'b0));
    xq.push_back(mk(2'd2, 32'h38, 1'b0, 3'd2, 3'd2, 32'h0, 32'h2222_0038, 0, 1'b0));
    xq.push_back(mk(2'd3, 32'h40, 1'b0, 3'd2, 3'd2, 32'h0, 32'h2222_0040, 0, 1'b0));
    run(40);

    // INCR4 write with BUSY between beats 2 and 3, then a fifth beat.
    xq.push_back(mk(2'd2, 32'h200, 1'b1, 3'd2, 3'd3, 32'hB000_0200, JUNK, 0, 1'b0));
    xq.push_back(mk(2'd3, 32'h204, 1'b1, 3'd2, 3'd3, 32'hB000_0204, JUNK, 2, 1'b0));
    xq.push_back(mk(2'd1, 32'h208, 1'b1, 3'd2, 3'd3, 32'h0, JUNK, 0, 1'b0));
    xq.push_back(mk(2'd3, 32'h208, 1'b1, 3'd2, 3'd3, 32'hB000_0208, JUNK, 0, 1'b0));
    xq.push_back(mk(2'd3, 32'h20C, 1'b1, 3'd2, 3'd3, 32'hB000_020C, JUNK, 0, 1'b0));
    xq.push_back(mk(2'd3, 32'h210, 1'b1, 3'd2, 3'd3, 32'hB000_0210, JUNK, 0, 1'b0));
    run(40);

    // Longest wait that still completes, then a timeout.
    xq.push_back(mk(2'd2, 32'h304, 1'b0, 3'd2, 3'd0, 32'h0, 32'h3333_0304, 5, 1'b0));
    xq.push_back(mk(2'd2, 32'h300, 1'b0, 3'd2, 3'd0, 32'h0, 32'h3333_0300, 20, 1'b0));
    run(40);

    // Backend error, next NONSEQ taken in the second error cycle.
    xq.push_back(mk(2'd2, 32'h400, 1'b1, 3'd2, 3'd0, 32'hC000_0400, JUNK, 0, 1'b1));
    xq.push_back(mk(2'd2, 32'h404, 1'b0, 3'd2, 3'd0, 32'h0, 32'h4444_0404, 0, 1'b0));
    run(20);

    // Protocol errors: oversize, BUSY/SEQ without a burst.
    xq.push_back(mk(2'd2, 32'h500, 1'b1, 3'd3, 3'd0, 32'hD000_0500, JUNK, 0, 1'b0));
    xq.push_back(mk(2'd1, 32'h500, 1'b0, 3'd2, 3'd1, 32'h0, JUNK, 0, 1'b0));
    xq.push_back(mk(2'd2, 32'h500, 1'b0, 3'd2, 3'd0, 32'h0, 32'h5555_0500, 0, 1'b0));
    xq.push_back(mk(2'd3, 32'h504, 1'b0, 3'd2, 3'd0, 32'h0, 32'h5555_0504, 0, 1'b0));
    run(30);

    // Undefined INCR halfword burst cut short by a NONSEQ byte read, then a mismatched burst type.
    xq.push_back(mk(2'd2, 32'h600, 1'b1, 3'd1, 3'd1, 32'hE000_0600, JUNK, 0, 1'b0));
    xq.push_back(mk(2'd3, 32'h602, 1'b1, 3'd1, 3'd1, 32'hE000_0602, JUNK, 1, 1'b0));
    xq.push_back(mk(2'd3, 32'h604, 1'b1, 3'd1, 3'd1, 32'hE000_0604, JUNK, 0, 1'b0));
    xq.push_back(mk(2'd2, 32'h701, 1'b0, 3'd0, 3'd3, 32'h0, 32'h6666_0701, 0, 1'b0));
    xq.push_back(mk(2'd3, 32'h702, 1'b0, 3'd0, 3'd5, 32'h0, 32'h6666_0702, 0, 1'b0));
    run(30);

    // Reset asserted in the middle of a waiting access.
    xq.push_back(mk(2'd2, 32'h7F0, 1'b1, 3'd2, 3'd0, 32'hF000_07F0, JUNK, 20, 1'b0));
    cycle();
    cycle();
    cycle();
    ordy = 1'b0; ordata = JUNK;
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    xq.delete();
    dq.delete();
    m_on = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
